// File: rtl/dphy_receiver.sv
// Single-lane MIPI D-PHY HS receiver: DDR-samples one data lane, hunts for the
// 0xB8 sync byte at either bit alignment, then deserialises LSB-first bytes.
module dphy_receiver (
   input  logic       clock_p,
   input  logic       reset,
   input  logic       data_p,
   output logic [7:0] data,
   output logic       enable
);

   typedef enum logic {
      HUNT    = 1'b0,
      RECEIVE = 1'b1
   } state_t;

   localparam logic [7:0] SYNC_BYTE = 8'hB8;

   state_t      r_state;
   state_t      w_state_next;
   logic        r_neg_bit;
   logic        r_pos_bit;
   logic        r_pair_vld;
   logic [15:0] r_hist;
   logic [4:0]  r_fill;
   logic [2:0]  r_bit_cnt;
   logic        r_odd;

   logic [15:0] w_hist_next;
   logic [4:0]  w_fill_next;
   logic        w_even_hit;
   logic        w_odd_hit;
   logic [3:0]  w_cnt_sum;
   logic [2:0]  w_bit_cnt_next;
   logic        w_odd_next;
   logic        w_byte_done;
   logic [7:0]  w_byte;

   // Later bit of each pair is captured on the falling edge.
   always_ff @(negedge clock_p or negedge reset) begin
      if (!reset) begin
         r_neg_bit <= 1'b0;
      end else begin
         r_neg_bit <= data_p;
      end
   end

   // History shifts toward bit 0; bit 15 is always the newest bit on the wire.
   always_comb begin
      w_hist_next = {r_neg_bit, r_pos_bit, r_hist[15:2]};
      w_fill_next = (r_fill >= 5'd15) ? 5'd16 : r_fill + 5'd2;
      w_even_hit  = (w_fill_next >= 5'd8) && (w_hist_next[15:8] == SYNC_BYTE);
      w_odd_hit   = (w_fill_next >= 5'd9) && (w_hist_next[14:7] == SYNC_BYTE);
      w_byte      = r_odd ? w_hist_next[14:7] : w_hist_next[15:8];
      w_cnt_sum   = {1'b0, r_bit_cnt} + 4'd2;
   end

   // Odd alignment starts the counter at 1: one payload bit is already held.
   always_comb begin
      w_state_next   = r_state;
      w_bit_cnt_next = r_bit_cnt;
      w_odd_next     = r_odd;
      w_byte_done    = 1'b0;
      if (r_pair_vld) begin
         case (r_state)
            HUNT: begin
               if (w_even_hit) begin
                  w_state_next   = RECEIVE;
                  w_bit_cnt_next = 3'd0;
                  w_odd_next     = 1'b0;
               end else if (w_odd_hit) begin
                  w_state_next   = RECEIVE;
                  w_bit_cnt_next = 3'd1;
                  w_odd_next     = 1'b1;
               end
            end
            RECEIVE: begin
               w_bit_cnt_next = w_cnt_sum[2:0];
               w_byte_done    = w_cnt_sum[3];
            end
            default: begin
               w_state_next = HUNT;
            end
         endcase
      end
   end

   always_ff @(posedge clock_p or negedge reset) begin
      if (!reset) begin
         r_state    <= HUNT;
         r_pos_bit  <= 1'b0;
         r_pair_vld <= 1'b0;
         r_hist     <= 16'h0000;
         r_fill     <= 5'd0;
         r_bit_cnt  <= 3'd0;
         r_odd      <= 1'b0;
         data       <= 8'h00;
         enable     <= 1'b0;
      end else begin
         r_pos_bit  <= data_p;
         r_pair_vld <= 1'b1;
         if (r_pair_vld) begin
            r_hist <= w_hist_next;
            r_fill <= w_fill_next;
         end
         r_state   <= w_state_next;
         r_bit_cnt <= w_bit_cnt_next;
         r_odd     <= w_odd_next;
         enable    <= w_byte_done;
         if (w_byte_done) begin
            data <= w_byte;
         end
      end
   end

endmodule

// File: tb/tb_dphy_receiver.sv
// Bench for dphy_receiver: drives a DDR bit stream one half-cycle at a time and
// scores every strobe (cycle and byte) against an expected queue.
module tb_dphy_receiver;

   logic       clock_p = 1'b0;
   logic       reset   = 1'b0;
   logic       data_p  = 1'b0;
   logic [7:0] data;
   logic       enable;

   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;
   logic [39:0] exp_q[$];
   logic [7:0]  held  = 8'h00;

   dphy_receiver dut (
      .clock_p (clock_p),
      .reset   (reset),
      .data_p  (data_p),
      .data    (data),
      .enable  (enable)
   );

   always #5 clock_p = ~clock_p;

   always @(posedge clock_p) cyc <= cyc + 1;

   // One wire bit per clock edge; after each falling edge the outputs are scored.
   task automatic half(input logic b);
      logic [39:0] e;
      logic [31:0] c;
      data_p = b;
      @(clock_p);
      #1;
      if (clock_p == 1'b0) begin
         c = cyc;
         total++;
         if (enable === 1'b1) begin
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL strobe_unexpected cyc=%0d data=%02h", cyc, data);
            end else begin
               e = exp_q.pop_front();
               if ({c, data} !== e) begin
                  bad++;
                  $display("FAIL strobe cyc=%0d data=%02h required cyc=%0d data=%02h",
                           cyc, data, e[39:8], e[7:0]);
               end
               held = e[7:0];
            end
         end else if (enable !== 1'b0 || data !== held) begin
            bad++;
            $display("FAIL idle cyc=%0d enable=%b data=%02h required enable=0 data=%02h",
                     cyc, enable, data, held);
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) half(1'b0);
   endtask

   task automatic send_byte(input logic [7:0] v);
      for (int i = 0; i < 8; i++) half(v[i]);
   endtask

   // pos=1: the next bit lands on a rising edge.
   task automatic align(input logic pos);
      if ((clock_p == 1'b0) != pos) half(1'b0);
   endtask

   task automatic send_sync(output int p);
      send_byte(8'hB8);
      p = cyc + 1;
   endtask

   task automatic push(input int p, input int n, input logic [7:0] v);
      logic [31:0] c;
      c = p + 4 + 4 * n;
      exp_q.push_back({c, v});
   endtask

   task automatic do_reset();
      reset = 1'b0;
      held  = 8'h00;
      for (int i = 0; i < 4; i++) half(1'($urandom_range(0, 1)));
      reset = 1'b1;
   endtask

   task automatic flush_check(input string name);
      idle(6);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL %s pending=%0d required 0", name, exp_q.size());
      end
      exp_q.delete();
   endtask

   task automatic test_reset();
      reset = 1'b0;
      held  = 8'h00;
      #1;
      total++;
      if (data !== 8'h00 || enable !== 1'b0) begin
         bad++;
         $display("FAIL reset_values data=%02h enable=%b required 00/0", data, enable);
      end
      for (int i = 0; i < 20; i++) half(1'($urandom_range(0, 1)));
      reset = 1'b1;
      flush_check("reset_quiet");
   endtask

   task automatic test_even_sync();
      int p;
      do_reset();
      align(1'b1);
      idle(6);
      send_sync(p);
      push(p, 0, 8'h12);
      push(p, 1, 8'h34);
      send_byte(8'h12);
      send_byte(8'h34);
      flush_check("even_sync");
   endtask

   task automatic test_odd_sync();
      int p;
      do_reset();
      align(1'b0);
      idle(6);
      send_sync(p);
      push(p, 0, 8'h12);
      push(p, 1, 8'h34);
      send_byte(8'h12);
      send_byte(8'h34);
      flush_check("odd_sync");
   endtask

   task automatic test_no_false_sync();
      do_reset();
      idle(6);
      send_byte(8'hB0);
      send_byte(8'h5C);
      send_byte(8'h3B);
      idle(16);
      flush_check("no_false_sync");
   endtask

   task automatic test_reset_mid_byte();
      int p;
      do_reset();
      align(1'b1);
      idle(6);
      send_sync(p);
      push(p, 0, 8'h3C);
      send_byte(8'h3C);
      for (int i = 0; i < 5; i++) half(1'b1);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL pre_reset_byte pending=%0d required 0", exp_q.size());
      end
      reset = 1'b0;
      held  = 8'h00;
      #1;
      total++;
      if (data !== 8'h00 || enable !== 1'b0) begin
         bad++;
         $display("FAIL mid_reset_clear data=%02h enable=%b required 00/0", data, enable);
      end
      half(1'b1);
      half(1'b1);
      reset = 1'b1;
      idle(6);
      send_sync(p);
      push(p, 0, 8'hA5);
      send_byte(8'hA5);
      flush_check("reset_mid_byte");
   endtask

   task automatic test_back_to_back();
      int p;
      do_reset();
      align(1'b1);
      idle(6);
      send_sync(p);
      for (int n = 0; n < 64; n++) push(p, n, 8'(n));
      for (int n = 0; n < 64; n++) send_byte(8'(n));
      flush_check("back_to_back");
   endtask

   initial begin
      test_reset();
      test_even_sync();
      test_odd_sync();
      test_no_false_sync();
      test_reset_mid_byte();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
